data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed, little-endian data memory with a request/ready/done handshake and configurable access latency. It supports byte, half and word accesses, with sign or zero extension on loads. Misaligned, out-of-range and illegal-size accesses are reported instead of silently wrapping. It is the next-generation data memory for the pipelined CPU's MEM stage and can model slow memory through wait cycles.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, >= 4.
ADDR_W, 32, width of addr_i.
LATENCY, 1, cycles from the accept edge to the access edge; >= 1.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, synchronous, active-high.
req_i  input  1  access request.
we_i  input  1  1 = store, 0 = load.
size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
unsigned_i  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
addr_i  input  ADDR_W  byte address.
data_i  input  32  store data; the low bytes are used.
ready_o  output  1  controller can accept a request this cycle.
done_o  output  1  one-cycle completion pulse.
data_o  output  32  load result; valid only while done_o = 1.
err_o  output  1  access fault; valid only while done_o = 1.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: ready_o = 1, done_o = 0, data_o = 0, err_o = 0, FSM in IDLE, wait counter = 0. Memory array contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- Accept: a request is accepted on a rising edge where req_i = 1 and ready_o = 1, in IDLE or DONE. we_i, size_i, unsigned_i, addr_i and data_i are latched at that edge and ignored afterwards.
- After accept (edge N):
  - The FSM enters WAIT and ready_o = 0.
  - The counter runs LATENCY-1 down to 0.
  - The memory access occurs at edge N+LATENCY; the FSM then enters DONE.
- In DONE, lasting exactly one cycle: done_o = 1, ready_o = 1, and data_o/err_o hold the result.
  - If req_i = 1 in DONE, the next request is accepted and the FSM goes to WAIT.
  - Otherwise it goes to IDLE.
  - Maximum throughput is one access per LATENCY+1 cycles.
- Requests without ready_o: req_i while ready_o = 0 is ignored. There is no queuing.
- Outside DONE: done_o = 0, err_o = 0, and data_o holds its last value.
- Fault check: fault = (size = 11) or (half and addr[0] != 0) or (word and addr[1:0] != 0) or (addr + bytes > DEPTH_BYTES). The range comparison uses the full ADDR_W+1-bit sum, so there is no wrap-around.
- Faulting access: no memory write, data_o = 0, err_o = 1.
- Store: writes 1, 2 or 4 bytes. Byte addr+k receives data_i[8k+7:8k]. data_o = 0 on a store.
- Load: bytes are assembled little-endian (byte at addr in bits [7:0]).
  - Byte/half loads: zero-extended if unsigned_i = 1, sign-extended from bit 7/15 otherwise.
  - Word loads: unsigned_i is ignored.
- Reset mid-operation: rst_i in WAIT aborts the access. A pending store whose access edge has not yet occurred is discarded. All outputs return to reset values on that edge.
- Read-after-write: a load accepted in the DONE cycle of a store observes the stored data.

Decomposition:
- Package data_mem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - FSM state enum.
  - Function returning the byte count for a size.
- Sub-module data_mem_ext: combinational load formatter taking 4 raw bytes, size and unsigned flag, producing the 32-bit extended result.
- The FSM, counter, fault check and byte array live in data_memory_ctrl.

Test Plan:
1. Reset, store word 0xDEADBEEF at 0x10, load word 0x10 (LATENCY = 1) -> done_o in the 2nd cycle after each accept, data_o = 0xDEADBEEF, err_o = 0.
2. After test 1, sub-word loads:
   - Byte 0x13 signed -> 0xFFFFFFDE; byte 0x13 unsigned -> 0x000000DE.
   - Half 0x12 signed -> 0xFFFFDEAD; half 0x10 unsigned -> 0x0000BEEF.
3. Store byte 0x55 at 0x11 and half 0x1234 at 0x12, then load word 0x10 -> 0x123455EF.
4. Faults:
   - Word store at 0x12 -> err_o = 1; a later load of 0x10 is unchanged.
   - Word at DEPTH_BYTES-2 -> err_o = 1.
   - size_i = 11 -> err_o = 1, data_o = 0.
5. LATENCY = 3 with req_i held high -> done_o every 4th cycle; addr_i changed while busy does not affect the result.
6. rst_i asserted in WAIT during a store to 0x20 -> next cycle ready_o = 1, done_o = 0; a load of 0x20 returns the pre-store contents.

Source files
------------

// File: rtl/data_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : data_mem_pkg                                          |
// | Purpose  : Shared encodings, FSM state type and size helper for  |
// |            the byte-addressed data memory controller.            |
// | Contents : SZ_* access-size codes, state_t, size_bytes()         |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package data_mem_pkg;

  // Access size encodings carried on size_i
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bytes touched by an access. The illegal code reports 4 so
  // the range check stays conservative; such accesses fault anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      SZ_ILL:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ext.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : data_mem_ext                                          |
// | Purpose  : Combinational load formatter. Takes the four raw      |
// |            little-endian bytes starting at the access address    |
// |            and produces the zero/sign-extended 32-bit result.    |
// | Ports    : raw     [31:0] in  - bytes addr..addr+3, addr in [7:0]|
// |            size    [1:0]  in  - access size code                 |
// |            uns            in  - 1 zero-extend, 0 sign-extend     |
// |            result  [31:0] out - formatted load value             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module data_mem_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~uns & raw[7];
  assign sign_h = ~uns & raw[15];

  always_comb begin
    result = raw;
    case (size)
      SZ_BYTE: result = {{24{sign_b}}, raw[7:0]};
      SZ_HALF: result = {{16{sign_h}}, raw[15:0]};
      default: result = raw;  // word loads ignore uns
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : data_memory_ctrl                                      |
// | Purpose  : Byte-addressed little-endian data memory with a       |
// |            req/ready/done handshake, configurable access         |
// |            latency and fault reporting for misaligned,           |
// |            out-of-range and illegal-size accesses.               |
// | Ports    : clk_i, rst_i (sync, active-high)                      |
// |            req_i, we_i, size_i, unsigned_i, addr_i, data_i       |
// |              - request, latched on the accept edge               |
// |            ready_o - request can be accepted this cycle          |
// |            done_o  - one-cycle completion pulse                  |
// |            data_o  - load result (valid with done_o)             |
// |            err_o   - access fault (valid with done_o)            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [31:0]       data_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH_BYTES);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               access;

  // Request fields captured on the accept edge
  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        rdata_q;
  logic               err_q;

  logic [2:0]         nbytes;
  logic [ADDR_W:0]    end_addr;
  logic               fault;
  logic [31:0]        rd_raw;
  logic [31:0]        ld_ext;

  logic [7:0]         mem [DEPTH_BYTES];
  logic [IDX_W-1:0]   lane_idx [4];

  // ------------------------------------------------------------------
  // Fault detection on the latched request. The end address is formed
  // one bit wider than the address so a request near the top of the
  // address space cannot wrap back into range.
  // ------------------------------------------------------------------
  assign nbytes   = size_bytes(size_q);
  assign end_addr = {1'b0, addr_q} + (ADDR_W + 1)'(nbytes);
  assign fault    = (size_q == SZ_ILL)
                  | ((size_q == SZ_HALF) & addr_q[0])
                  | ((size_q == SZ_WORD) & (|addr_q[1:0]))
                  | (end_addr > DEPTH_LIM);

  // Byte lanes: lane k addresses addr+k. Index wrap inside the array is
  // harmless since any access that would wrap is a fault and is masked.
  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      assign lane_idx[k]     = addr_q[IDX_W-1:0] + IDX_W'(k);
      assign rd_raw[8*k +: 8] = mem[lane_idx[k]];
    end
  endgenerate

  data_mem_ext u_ext (
    .raw    (rd_raw),
    .size   (size_q),
    .uns    (uns_q),
    .result (ld_ext)
  );

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_i) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        if (req_i) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The access edge is the last WAIT cycle; reset on that edge cancels it.
  assign access = (state == ST_WAIT) && (cnt == '0) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= we_i;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        addr_q  <= addr_i;
        wdata_q <= data_i;
      end
      if (access) begin
        err_q   <= fault;
        rdata_q <= (fault || we_q) ? 32'd0 : ld_ext;
      end
    end
  end

  // Byte array: not reset, written only by a non-faulting store.
  always_ff @(posedge clk_i) begin
    if (access && we_q && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(nbytes)) begin
          mem[lane_idx[k]] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign ready_o = (state != ST_WAIT);
  assign done_o  = (state == ST_DONE);
  assign data_o  = rdata_q;
  assign err_o   = (state == ST_DONE) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_data_memory_ctrl                                   |
// | Purpose  : Self-checking bench for data_memory_ctrl. Instance 0   |
// |            runs with LATENCY=1, instance 1 with LATENCY=3.       |
// |            Expected results are queued when a request is driven  |
// |            and compared when done_o fires.                       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_data_memory_ctrl;
  import data_mem_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req, we, uns;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0]       ready, done, err;

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .unsigned_i(uns[0]), .addr_i(addr[0]), .data_i(wdata[0]),
    .ready_o(ready[0]), .done_o(done[0]), .data_o(rdata[0]), .err_o(err[0])
  );

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .unsigned_i(uns[1]), .addr_i(addr[1]), .data_i(wdata[1]),
    .ready_o(ready[1]), .done_o(done[1]), .data_o(rdata[1]), .err_o(err[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_req(input int d, input logic we_v, input logic [1:0] sz,
                          input logic uns_v, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic ee);
    exp_t e;
    req[d]   = 1'b1;
    we[d]    = we_v;
    size[d]  = sz;
    uns[d]   = uns_v;
    addr[d]  = a;
    wdata[d] = wd;
    e.data   = ed;
    e.err    = ee;
    sb_q.push_back(e);
  endtask

  // Called at the first negedge after the accept edge; returns at the
  // negedge inside the DONE cycle.
  task automatic wait_done(input int d, input string tag);
    int   n;
    int   lat;
    exp_t e;
    lat = (d == 0) ? 1 : 3;
    n   = 0;
    while (!done[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_rdy"}, {31'd0, ready[d]}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_data"}, rdata[d], e.data);
      check({tag, "_err"}, {31'd0, err[d]}, {31'd0, e.err});
    end
  endtask

  task automatic xact(input int d, input bit b2b, input logic we_v, input logic [1:0] sz,
                      input logic uns_v, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input string tag);
    if (!b2b) @(negedge clk);
    push_req(d, we_v, sz, uns_v, a, wd, ed, ee);
    @(negedge clk);
    req[d] = 1'b0;
    wait_done(d, tag);
  endtask

  logic [31:0] l3_addr [3];
  logic [31:0] l3_data [3];

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    uns   = '0;
    size  = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), {31'd0, ready[d]}, 32'd1);
      check($sformatf("rst_done%0d", d),  {31'd0, done[d]},  32'd0);
      check($sformatf("rst_data%0d", d),  rdata[d],          32'd0);
      check($sformatf("rst_err%0d", d),   {31'd0, err[d]},   32'd0);
    end
    rst = 1'b0;

    // Word store / load
    xact(0, 0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st_w10");
    xact(0, 0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w10");

    // Sub-word loads
    xact(0, 0, 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, "ld_b13_s");
    xact(0, 0, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h000000DE, 0, "ld_b13_u");
    xact(0, 0, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, "ld_h12_s");
    xact(0, 0, 0, SZ_HALF, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, "ld_h10_u");

    // Partial stores, then a load accepted in the store's DONE cycle
    xact(0, 0, 1, SZ_BYTE, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0, "st_b11");
    xact(0, 0, 1, SZ_HALF, 0, 32'h12, 32'hFFFF1234, 32'h0, 0, "st_h12");
    xact(0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h123455EF, 0, "ld_w10_raw");
    xact(0, 0, 0, SZ_WORD, 1, 32'h10, 32'h0, 32'h123455EF, 0, "ld_w10_uns");

    // Faults
    xact(0, 0, 1, SZ_WORD, 0, 32'h12, 32'h99999999, 32'h0, 1, "st_w12_mis");
    xact(0, 0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h123455EF, 0, "ld_w10_keep");
    xact(0, 0, 0, SZ_WORD, 0, DEPTH - 2, 32'h0, 32'h0, 1, "ld_w_dm2");
    xact(0, 0, 0, SZ_WORD, 0, DEPTH, 32'h0, 32'h0, 1, "ld_w_depth");
    xact(0, 0, 0, SZ_WORD, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, "ld_w_wrap");
    xact(0, 0, 0, SZ_HALF, 0, 32'h11, 32'h0, 32'h0, 1, "ld_h_mis");
    xact(0, 0, 0, SZ_ILL, 0, 32'h10, 32'h0, 32'h0, 1, "ld_ill");
    xact(0, 0, 1, SZ_HALF, 0, DEPTH - 2, 32'h0000BEEF, 32'h0, 0, "st_h_top");
    xact(0, 0, 0, SZ_HALF, 1, DEPTH - 2, 32'h0, 32'h0000BEEF, 0, "ld_h_top");
    xact(0, 0, 0, SZ_BYTE, 0, DEPTH - 1, 32'h0, 32'hFFFFFFBE, 0, "ld_b_top");

    // LATENCY=3 instance: preload
    l3_addr[0] = 32'h0;  l3_data[0] = 32'h11111111;
    l3_addr[1] = 32'h4;  l3_data[1] = 32'h22222222;
    l3_addr[2] = 32'h8;  l3_data[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      xact(1, 0, 1, SZ_WORD, 0, l3_addr[i], l3_data[i], 32'h0, 0, $sformatf("l3_st%0d", i));
    end
    xact(1, 0, 1, SZ_WORD, 0, 32'h20, 32'h11223344, 32'h0, 0, "l3_st20");

    // req held high: new accept in every DONE cycle, addr scribbled while busy
    @(negedge clk);
    push_req(1, 0, SZ_WORD, 0, l3_addr[0], 32'h0, l3_data[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr[1] = 32'h0000_0008 - l3_addr[i] + 32'h4;
      wait_done(1, $sformatf("l3_hold%0d", i));
      if (i < 2) push_req(1, 0, SZ_WORD, 0, l3_addr[i+1], 32'h0, l3_data[i+1], 0);
      else       req[1] = 1'b0;
    end

    // Reset while a store is waiting for its access edge
    @(negedge clk);
    req[1]   = 1'b1;
    we[1]    = 1'b1;
    size[1]  = SZ_WORD;
    addr[1]  = 32'h20;
    wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    req[1] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ready[1]}, 32'd1);
    check("abort_done",  {31'd0, done[1]},  32'd0);
    check("abort_err",   {31'd0, err[1]},   32'd0);
    check("abort_data",  rdata[1],          32'd0);
    xact(1, 0, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h11223344, 0, "l3_ld20");

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
